nv_memory_array: RTL
====================

# nv_memory_array

Parametrised non-volatile configuration memory model for the secured-bitstream flow. It provides a single-port word array with registered reads, per-word one-time write lock, and a sequenced bulk erase. It sits between the bitstream/key controller and the fabric configuration logic. It generalises the fixed 256 x 64 `nv_memory` with configurable geometry, explicit request/valid/busy handshakes, and error reporting.

## Interface
- `DATA_W`, 64, word width in bits
- `ADDR_W`, 8, address width; depth is `DEPTH = 2**ADDR_W`
- `ERASE_VAL`, `{DATA_W{1'b0}}`, value written to every word by erase
- `fpga_clk`  in  1  sole clock; all logic on the rising edge
- `fpga_rst`  in  1  synchronous, active-high reset
- `mem_en`  in  1  request strobe; sampled on each rising edge
- `mem_rw`  in  1  0 = write, 1 = read; qualified by `mem_en`
- `mem_lock`  in  1  with a write: also sets the lock bit of the addressed word
- `mem_erase`  in  1  erase start strobe
- `mem_addr_in`  in  ADDR_W  word address
- `mem_data_in`  in  DATA_W  write data
- `mem_data_out`  out  DATA_W  read data; holds its value between reads
- `mem_data_valid`  out  1  one-cycle pulse marking new `mem_data_out`
- `mem_busy`  out  1  high while an erase sweep runs
- `mem_err`  out  1  one-cycle pulse when a request is rejected

## Operation
- Storage: `DEPTH` x `DATA_W` data array plus a `DEPTH` x 1 lock array.
  - Both initialise to `ERASE_VAL` / 0 at time zero.
  - Neither is touched by `fpga_rst`, because the contents are non-volatile.
- Controller FSM has two states, IDLE and ERASE. Reset value is IDLE.
- IDLE:
  - `mem_erase`=1 enters ERASE with the sweep pointer at 0. It has priority over `mem_en` in the same cycle; any coincident request is dropped and `mem_err` pulses.
  - Write (`mem_en`=1, `mem_rw`=0):
    - If the word's lock bit is 0, store `mem_data_in`, and set the lock bit if `mem_lock`=1.
    - If the lock bit is 1, the array is unchanged and `mem_err` pulses.
  - Read (`mem_en`=1, `mem_rw`=1): `mem_data_out` <= array[addr] and `mem_data_valid` pulses. Reading locked words is allowed.
  - `mem_lock` is ignored on reads.
- ERASE:
  - Each cycle writes `ERASE_VAL` to array[ptr], clears lock[ptr], and increments ptr.
  - After ptr = `DEPTH-1` is written, return to IDLE. The pointer does not wrap.
  - `mem_en`=1 during ERASE: request dropped, `mem_err` pulses.
  - `mem_erase` during ERASE is ignored, with no error and no restart.
- Reset mid-erase: FSM returns to IDLE and `mem_busy` goes low. Words below the pointer stay erased and unlocked; words at or above it keep their old data and locks.
- Address is always in range, since `DEPTH = 2**ADDR_W`.

## Timing
- Reset values:
  - `mem_data_out` = 0
  - `mem_data_valid` = 0
  - `mem_busy` = 0
  - `mem_err` = 0
  - FSM = IDLE, sweep pointer = 0
- Read latency is 1: a request sampled at edge N gives `mem_data_out`/`mem_data_valid` updated at edge N, visible during cycle N+1. `mem_data_valid` is high for exactly one cycle per accepted read.
- Write is committed at its sampling edge. A read of the same address at the next edge returns the new data.
- Back-to-back requests are accepted every cycle in IDLE, with no bubbles.
- `mem_err` is registered: high for the one cycle after the rejected request edge.
- Erase timing:
  - `mem_erase` sampled at edge E raises `mem_busy` after E.
  - Word k is written at edge E+1+k.
  - `mem_busy` falls after edge E+DEPTH, so it is high for exactly `DEPTH` cycles.
  - The first request can be accepted at edge E+DEPTH+1.
- `fpga_rst` overrides every other input in the cycle it is sampled. Requests presented in that cycle are dropped silently (no `mem_err`).

## Test plan
- Defaults, write 256→addr 0, 555→addr 1, 2560→addr 200, then read 0, 1, 200 back-to-back → `mem_data_out` = 256, 555, 2560 on consecutive cycles, each with a one-cycle `mem_data_valid`.
- Write 0xA5 with `mem_lock`=1 to addr 5, then write 0x3C to addr 5 → `mem_err` pulses once; a read of addr 5 returns 0xA5.
- Pulse `mem_erase` with addr 5 locked and addr 200 = 2560 → `mem_busy` high for exactly 256 cycles. Afterwards reads of 5 and 200 return 0. A write of 0x11 to addr 5 then succeeds with no `mem_err`.
- During an erase, issue a read and a second `mem_erase` → the read gets `mem_err` and no `mem_data_valid`; `mem_busy` still drops after 256 cycles total.
- Fill addrs 0–9 with 0xFF, start an erase, assert `fpga_rst` after 4 sweep writes → `mem_busy` = 0 the next cycle. Addrs 0–3 read 0, addrs 4–9 read 0xFF, and `mem_data_out` = 0 right after reset.
- `DATA_W`=32, `ADDR_W`=4: assert `mem_erase` and `mem_en` (write) in the same cycle → the write is dropped with `mem_err`. Erase lasts 16 cycles, and a readback of all 16 words returns `ERASE_VAL`.

Source files
------------

// File: rtl/nv_memory_array.sv
// Non-volatile configuration word array: registered reads, per-word write-once lock,
// and a sequenced bulk erase that sweeps one word per cycle.
module nv_memory_array #(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 8,
    parameter logic [DATA_W-1:0] ERASE_VAL = '0
) (
    input  logic              fpga_clk,
    input  logic              fpga_rst,
    input  logic              mem_en,
    input  logic              mem_rw,
    input  logic              mem_lock,
    input  logic              mem_erase,
    input  logic [ADDR_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_data_valid,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        ERASE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic              lockWe;
    logic              lockWdata;

    // Contents model non-volatile storage: initialised once, never cleared by reset.
    logic [DATA_W-1:0] mem_q  [DEPTH] = '{default: ERASE_VAL};
    logic              lock_q [DEPTH] = '{default: 1'b0};

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        memWe     = 1'b0;
        memAddr   = mem_addr_in;
        memWdata  = mem_data_in;
        lockWe    = 1'b0;
        lockWdata = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_erase) begin
                    state_d = ERASE;
                    ptr_d   = '0;
                    err_d   = mem_en;
                end else if (mem_en) begin
                    if (mem_rw) begin
                        data_d  = mem_q[mem_addr_in];
                        valid_d = 1'b1;
                    end else if (lock_q[mem_addr_in]) begin
                        err_d = 1'b1;
                    end else begin
                        memWe     = 1'b1;
                        lockWe    = mem_lock;
                        lockWdata = 1'b1;
                    end
                end
            end
            ERASE: begin
                memWe     = 1'b1;
                memAddr   = ptr_q;
                memWdata  = ERASE_VAL;
                lockWe    = 1'b1;
                lockWdata = 1'b0;
                err_d     = mem_en;
                // Sweep ends on the last word rather than wrapping the pointer.
                if (&ptr_q) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (fpga_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (!fpga_rst && memWe) begin
            mem_q[memAddr] <= memWdata;
        end
        if (!fpga_rst && lockWe) begin
            lock_q[memAddr] <= lockWdata;
        end
    end

    assign mem_data_out   = data_q;
    assign mem_data_valid = valid_q;
    assign mem_busy       = (state_q == ERASE);
    assign mem_err        = err_q;

endmodule
